// File: rtl/pixel_path_scaled_if.sv
// Frame-buffer read bus between the pixel path (master) and the front frame-buffer BRAM (slave).
//   rd_addr_pix : word address of the pixel being fetched
//   rd_en_pix   : read strobe, high only for visible pixels
//   rd_data_pix : read data, valid RD_LAT cycles after the strobe
interface pixel_path_scaled_if #(
   parameter int unsigned ADDR_W = 17
);
   logic [ADDR_W-1:0] rd_addr_pix;
   logic              rd_en_pix;
   logic [15:0]       rd_data_pix;

   modport master (
      output rd_addr_pix,
      output rd_en_pix,
      input  rd_data_pix
   );

   modport slave (
      input  rd_addr_pix,
      input  rd_en_pix,
      output rd_data_pix
   );
endinterface

// File: rtl/pixel_path_scaled.sv
// Pixel path for the VGA output: turns raster counters into frame-buffer read addresses with a
// power-of-two upscale, converts the returned words to 12-bit colour, overlays an optional
// border and delays the syncs so that they line up exactly with the pixel data.
//   pix_clk, prst        : pixel clock, synchronous active-high reset
//   h_cnt, v_cnt         : raster counters from the timing generator
//   h_sync, v_sync       : active-low syncs aligned with the counters
//   border_en/border_rgb : border overlay control and colour (quasi-static)
//   fb                   : frame-buffer read bus (master side)
//   vga_hsync/vsync/rgb  : outputs to the VGA pins, all with latency RD_LAT+2
//   frame_start          : one-cycle pulse with the first visible pixel of a frame
module pixel_path_scaled #(
   parameter int unsigned W_VIS       = 640,
   parameter int unsigned H_VIS       = 480,
   parameter int unsigned H_TOTAL     = 800,
   parameter int unsigned V_TOTAL     = 525,
   parameter int unsigned SCALE_SHIFT = 1,
   parameter int unsigned W_FB        = W_VIS >> SCALE_SHIFT,
   parameter int unsigned ADDR_W      = 17,
   parameter int unsigned RD_LAT      = 1,
   parameter int unsigned PIX_FMT     = 0
) (
   input  logic                         pix_clk,
   input  logic                         prst,
   input  logic [$clog2(H_TOTAL)-1:0]   h_cnt,
   input  logic [$clog2(V_TOTAL)-1:0]   v_cnt,
   input  logic                         h_sync,
   input  logic                         v_sync,
   input  logic                         border_en,
   input  logic [11:0]                  border_rgb,
   pixel_path_scaled_if.master          fb,
   output logic                         vga_hsync,
   output logic                         vga_vsync,
   output logic [11:0]                  vga_rgb,
   output logic                         frame_start
);

   localparam int unsigned L  = RD_LAT + 2;
   // y_sub needs at least one bit even at 1x; it then simply stays 0.
   localparam int unsigned YW = (SCALE_SHIFT == 0) ? 1 : SCALE_SHIFT;
   localparam logic [YW-1:0] YLast = YW'((1 << SCALE_SHIFT) - 1);

   // Stage 0: counter decode and address generation
   logic              active, border, first, line_end;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] row_base_d, row_base_q;
   logic [YW-1:0]     y_sub_d, y_sub_q;

   always_comb begin
      active   = (32'(h_cnt) < W_VIS) && (32'(v_cnt) < H_VIS);
      border   = active && ((h_cnt == '0) || (32'(h_cnt) == W_VIS - 1) ||
                            (v_cnt == '0) || (32'(v_cnt) == H_VIS - 1));
      first    = (h_cnt == '0) && (v_cnt == '0);
      addr     = row_base_q + ADDR_W'(h_cnt >> SCALE_SHIFT);
      line_end = (32'(h_cnt) == H_TOTAL - 1);

      row_base_d = row_base_q;
      y_sub_d    = y_sub_q;
      if (line_end && (32'(v_cnt) == V_TOTAL - 1)) begin
         // Frame wrap wins over the per-line advance.
         row_base_d = '0;
         y_sub_d    = '0;
      end else if (line_end && (32'(v_cnt) < H_VIS)) begin
         if (y_sub_q == YLast) begin
            y_sub_d    = '0;
            row_base_d = row_base_q + ADDR_W'(W_FB);
         end else begin
            y_sub_d = y_sub_q + YW'(1);
         end
      end
   end

   always_ff @(posedge pix_clk) begin
      if (prst) begin
         row_base_q <= '0;
         y_sub_q    <= '0;
      end else begin
         row_base_q <= row_base_d;
         y_sub_q    <= y_sub_d;
      end
   end

   // Stage 1: frame-buffer read request
   logic [ADDR_W-1:0] rd_addr_q;
   logic              rd_en_q;

   always_ff @(posedge pix_clk) begin
      if (prst) begin
         rd_addr_q <= '0;
         rd_en_q   <= 1'b0;
      end else begin
         rd_addr_q <= addr;
         rd_en_q   <= active;
      end
   end

   assign fb.rd_addr_pix = rd_addr_q;
   assign fb.rd_en_pix   = rd_en_q;

   // Delay lines. Syncs and first run through L registers. active/border only need L-1,
   // because the colour register below is the L-th stage of their path.
   logic [2:0] sync_q [L];    // {hsync, vsync, first}
   logic [1:0] flag_q [L-1];  // {active, border}

   always_ff @(posedge pix_clk) begin
      if (prst) begin
         for (int unsigned i = 0; i < L; i++) begin
            sync_q[i] <= 3'b110;
         end
         for (int unsigned i = 0; i < L - 1; i++) begin
            flag_q[i] <= 2'b00;
         end
      end else begin
         sync_q[0] <= {h_sync, v_sync, first};
         for (int unsigned i = 1; i < L; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         flag_q[0] <= {active, border};
         for (int unsigned i = 1; i < L - 1; i++) begin
            flag_q[i] <= flag_q[i-1];
         end
      end
   end

   // Colour conversion and output register
   logic [11:0] colour;
   logic [11:0] rgb_q;
   logic        active_d, border_d;

   always_comb begin
      if (PIX_FMT == 1) begin
         // Top four bits of each of R5, G6, B5.
         colour = {fb.rd_data_pix[15:12], fb.rd_data_pix[10:7], fb.rd_data_pix[4:1]};
      end else begin
         colour = fb.rd_data_pix[11:0];
      end
      active_d = flag_q[L-2][1];
      border_d = flag_q[L-2][0];
   end

   always_ff @(posedge pix_clk) begin
      if (prst) begin
         rgb_q <= 12'h000;
      end else if (!active_d) begin
         rgb_q <= 12'h000;
      end else if (border_d && border_en) begin
         rgb_q <= border_rgb;
      end else begin
         rgb_q <= colour;
      end
   end

   assign vga_hsync   = sync_q[L-1][2];
   assign vga_vsync   = sync_q[L-1][1];
   assign frame_start = sync_q[L-1][0];
   assign vga_rgb     = rgb_q;

endmodule

// File: tb/tb_pixel_path_scaled.sv
// Randomised scoreboard bench for pixel_path_scaled on a shrunken raster.
module tb_pixel_path_scaled;

   localparam int unsigned W_VIS       = 16;
   localparam int unsigned H_VIS       = 12;
   localparam int unsigned H_TOTAL     = 24;
   localparam int unsigned V_TOTAL     = 16;
   localparam int unsigned SCALE_SHIFT = 1;
   localparam int unsigned W_FB        = W_VIS >> SCALE_SHIFT;
   localparam int unsigned ADDR_W      = 10;
   localparam int unsigned RD_LAT      = 2;
   localparam int unsigned PIX_FMT     = 1;
   localparam int unsigned L           = RD_LAT + 2;
   localparam int unsigned HW          = $clog2(H_TOTAL);
   localparam int unsigned VW          = $clog2(V_TOTAL);
   localparam int unsigned NFRAMES     = 8;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        fs;
      logic [11:0] rgb;
   } exp_t;

   typedef struct packed {
      logic              en;
      logic [ADDR_W-1:0] addr;
   } rd_t;

   logic          clk = 1'b0;
   logic          prst;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          h_sync, v_sync;
   logic          border_en;
   logic [11:0]   border_rgb;
   logic          vga_hsync, vga_vsync, frame_start;
   logic [11:0]   vga_rgb;

   pixel_path_scaled_if #(.ADDR_W(ADDR_W)) fb_if ();

   pixel_path_scaled #(
      .W_VIS      (W_VIS),
      .H_VIS      (H_VIS),
      .H_TOTAL    (H_TOTAL),
      .V_TOTAL    (V_TOTAL),
      .SCALE_SHIFT(SCALE_SHIFT),
      .W_FB       (W_FB),
      .ADDR_W     (ADDR_W),
      .RD_LAT     (RD_LAT),
      .PIX_FMT    (PIX_FMT)
   ) dut (
      .pix_clk    (clk),
      .prst       (prst),
      .h_cnt      (h_cnt),
      .v_cnt      (v_cnt),
      .h_sync     (h_sync),
      .v_sync     (v_sync),
      .border_en  (border_en),
      .border_rgb (border_rgb),
      .fb         (fb_if),
      .vga_hsync  (vga_hsync),
      .vga_vsync  (vga_vsync),
      .vga_rgb    (vga_rgb),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   // BRAM model: fixed latency of RD_LAT cycles from address to data.
   logic [15:0]       mem [1 << ADDR_W];
   logic [ADDR_W-1:0] ap_q [RD_LAT];

   always @(posedge clk) begin
      ap_q[0] <= fb_if.rd_addr_pix;
      for (int i = 1; i < RD_LAT; i++) ap_q[i] <= ap_q[i-1];
   end
   assign fb_if.rd_data_pix = mem[ap_q[RD_LAT-1]];

   // Scoreboard
   exp_t sb_q[$];
   rd_t  rd_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   k_lines  = 0;  // visible lines completed since the last frame wrap or reset
   int   h = 0, v = 0;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] rgb565_to_444(input logic [15:0] d);
      int r, g, b;
      r = int'(d) / 2048;
      g = (int'(d) / 32) % 64;
      b = int'(d) % 32;
      return 12'((r / 2) * 256 + (g / 4) * 16 + (b / 2));
   endfunction

   // Drive the counters/syncs for the current cycle and queue what the pins must show.
   task automatic apply_cycle();
      exp_t e;
      rd_t  a;
      int   addr;
      bit   act, bord;
      h_cnt  = HW'(h);
      v_cnt  = VW'(v);
      h_sync = !(h >= 18 && h < 21);
      v_sync = !(v == 13);
      act  = (h < W_VIS) && (v < H_VIS);
      bord = act && (h == 0 || h == W_VIS - 1 || v == 0 || v == H_VIS - 1);
      addr = (k_lines >> SCALE_SHIFT) * W_FB + (h >> SCALE_SHIFT);
      a.en   = act && !prst;
      a.addr = ADDR_W'(addr);
      e.hs  = h_sync;
      e.vs  = v_sync;
      e.fs  = (h == 0) && (v == 0);
      e.rgb = !act ? 12'h000 : (bord && border_en) ? border_rgb :
              (PIX_FMT == 1) ? rgb565_to_444(mem[addr]) : mem[addr][11:0];
      sb_q.push_back(e);
      rd_q.push_back(a);
      if (prst) begin
         // A reset edge flushes everything still in flight, including this cycle.
         for (int i = (sb_q.size() > L) ? sb_q.size() - L : 0; i < sb_q.size(); i++)
            sb_q[i] = '{hs: 1'b1, vs: 1'b1, fs: 1'b0, rgb: 12'h000};
         k_lines = 0;
      end else if (h == H_TOTAL - 1) begin
         if (v == V_TOTAL - 1) k_lines = 0;
         else if (v < H_VIS) k_lines++;
      end
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > L) begin
         exp_t e;
         e = sb_q.pop_front();
         check("vga_hsync", int'(vga_hsync), int'(e.hs));
         check("vga_vsync", int'(vga_vsync), int'(e.vs));
         check("frame_start", int'(frame_start), int'(e.fs));
         check("vga_rgb", int'(vga_rgb), int'(e.rgb));
      end
      if (rd_q.size() > 1) begin
         rd_t a;
         a = rd_q.pop_front();
         check("rd_en_pix", int'(fb_if.rd_en_pix), int'(a.en));
         if (a.en) check("rd_addr_pix", int'(fb_if.rd_addr_pix), int'(a.addr));
      end
   end

   initial begin
      int rst_at, rst_len;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'($urandom);
      mem[0] = 16'hF81F;  // magenta -> F0F
      mem[1] = 16'h07E0;  // green   -> 0F0
      border_en  = 1'b0;
      border_rgb = 12'h000;
      prst = 1'b1;
      h = 0;
      v = 0;
      for (int i = 0; i < 3; i++) begin
         apply_cycle();
         @(posedge clk);
         #1;
      end
      prst = 1'b0;
      for (int f = 0; f < NFRAMES; f++) begin
         border_en  = (f == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         border_rgb = (f == 1) ? 12'hABC : 12'($urandom);
         rst_at  = (f == 3 || f == 5) ? int'($urandom_range(60, 300)) : -10;
         rst_len = int'($urandom_range(1, 3));
         for (int i = 0; i < int'(H_TOTAL * V_TOTAL); i++) begin
            h = i % H_TOTAL;
            v = i / H_TOTAL;
            prst = (i >= rst_at) && (i < rst_at + rst_len);
            apply_cycle();
            @(posedge clk);
            #1;
         end
      end
      // Start one more frame so the tail of the last one drains through the monitor.
      prst = 1'b0;
      for (int i = 0; i < int'(L) + 2; i++) begin
         h = i;
         v = 0;
         apply_cycle();
         @(posedge clk);
         #1;
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
